// File: rtl/seq_det_pkg.sv
// Shared types for the 1011 serial link: transmitter FSM states and the reference pattern.
package seq_det_pkg;

   typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE} tx_state_t;

   localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Start/abort request and serial output bundle between a requester and seq_pattern_tx.
interface seq_pattern_tx_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) ();

   logic             start_valid;
   logic             start_ready;
   logic             use_default;
   logic [PAT_W-1:0] pat_in;
   logic [CNT_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_len;
   logic             abort;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic             done;

   modport master (
      output start_valid, use_default, pat_in, rep_cnt, gap_len, abort,
      input  start_ready, dout, dout_valid, busy, done
   );

   modport slave (
      input  start_valid, use_default, pat_in, rep_cnt, gap_len, abort,
      output start_ready, dout, dout_valid, busy, done
   );

endinterface

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; msb presents the bit that will be sent next.
// Load has priority over shift; zero fill on shift.
module seq_piso #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[W-2:0], 1'b0};
      end
   end

   assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first R times with optional idle gaps.
// First bit one cycle after the start handshake; start_ready only in IDLE with abort low.
module seq_pattern_tx
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PAT_1011,
   parameter int               CNT_W   = 8,
   parameter int               GAP_W   = 4
) (
   input logic             clk,
   input logic             rst_n,
   seq_pattern_tx_if.slave bus
);

   localparam int              BI_W     = $clog2(PAT_W);
   localparam logic [BI_W-1:0] BIT_LAST = BI_W'(PAT_W - 1);

   tx_state_t        state;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] rep_q;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [BI_W-1:0]  bit_idx;

   logic             dout_q;
   logic             dout_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             start_ready;
   logic             accept;
   logic [PAT_W-1:0] pat_sel;
   logic [PAT_W-1:0] launch_pat;
   logic             piso_load;
   logic             piso_shift;
   logic             piso_msb;
   logic             more_reps;
   logic             last_bit;

   assign start_ready = (state == IDLE) && !bus.abort;
   assign accept      = bus.start_valid && start_ready;
   assign pat_sel     = bus.use_default ? PATTERN : bus.pat_in;
   assign more_reps   = rep_q > CNT_W'(1);
   assign last_bit    = (bit_idx == '0);

   // The register holds the bits after the one on dout, so a launch loads the pattern shifted by one.
   always_comb begin
      launch_pat = accept ? pat_sel : pat_q;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      case (state)
         IDLE:  piso_load = accept;
         SHIFT: begin
            if (!bus.abort) begin
               if (!last_bit) begin
                  piso_shift = 1'b1;
               end else if (more_reps && (gap_q == '0)) begin
                  piso_load = 1'b1;
               end
            end
         end
         GAP:     piso_load = !bus.abort && (gap_cnt == GAP_W'(1));
         default: ;
      endcase
   end

   seq_piso #(.W(PAT_W)) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (piso_load),
      .shift (piso_shift),
      .din   ({launch_pat[PAT_W-2:0], 1'b0}),
      .msb   (piso_msb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pat_q        <= '0;
         rep_q        <= '0;
         gap_q        <= '0;
         gap_cnt      <= '0;
         bit_idx      <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else if (bus.abort && (state != IDLE)) begin
         state        <= IDLE;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  state        <= SHIFT;
                  pat_q        <= pat_sel;
                  rep_q        <= (bus.rep_cnt == '0) ? CNT_W'(1) : bus.rep_cnt;
                  gap_q        <= bus.gap_len;
                  bit_idx      <= BIT_LAST;
                  dout_q       <= pat_sel[PAT_W-1];
                  dout_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
               end else begin
                  dout_q       <= 1'b0;
                  dout_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            SHIFT: begin
               if (!last_bit) begin
                  bit_idx <= bit_idx - BI_W'(1);
                  dout_q  <= piso_msb;
               end else if (more_reps) begin
                  rep_q <= rep_q - CNT_W'(1);
                  if (gap_q != '0) begin
                     state        <= GAP;
                     gap_cnt      <= gap_q;
                     dout_q       <= 1'b0;
                     dout_valid_q <= 1'b0;
                  end else begin
                     bit_idx <= BIT_LAST;
                     dout_q  <= pat_q[PAT_W-1];
                  end
               end else begin
                  state        <= DONE;
                  dout_q       <= 1'b0;
                  dout_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(1)) begin
                  state        <= SHIFT;
                  bit_idx      <= BIT_LAST;
                  dout_q       <= pat_q[PAT_W-1];
                  dout_valid_q <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               dout_q       <= 1'b0;
               dout_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.start_ready = start_ready;
   assign bus.dout        = dout_q;
   assign bus.dout_valid  = dout_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed requests push expected bits/done cycles; a monitor pops and compares.
module tb_seq_pattern_tx;
   import seq_det_pkg::*;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   seq_pattern_tx #(
      .PAT_W   (PAT_W),
      .PATTERN (PAT_1011),
      .CNT_W   (CNT_W),
      .GAP_W   (GAP_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int   cyc;
      logic bit_v;
   } bit_exp_t;

   bit_exp_t   bit_q[$];
   int         done_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         det_cnt = 0;
   logic [2:0] hist = 3'b000;
   bit         mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: output seen with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: samples at negedge, pops the scoreboard, runs a small 1011 detector on valid bits.
   initial begin
      bit_exp_t e;
      int       dc;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.dout_valid) begin
               if (bit_q.size() == 0) begin
                  unexpected("bit_extra");
               end else begin
                  e = bit_q.pop_front();
                  check("bit_cycle", cyc, e.cyc);
                  check("bit_value", bus.dout, e.bit_v);
               end
               if ({hist, bus.dout} == 4'b1011) det_cnt++;
               hist = {hist[1:0], bus.dout};
            end else begin
               check("dout_idle_zero", bus.dout, 0);
            end
            if (bus.done) begin
               if (done_q.size() == 0) begin
                  unexpected("done_extra");
               end else begin
                  dc = done_q.pop_front();
                  check("done_cycle", cyc, dc);
               end
            end
         end
      end
   end

   task automatic push_exp(input logic [3:0] pat, input int r, input int gap, input int n,
                           input int nbits, input bit exp_done);
      int k = 0;
      for (int i = 0; i < r; i++) begin
         for (int b = 0; b < PAT_W; b++) begin
            if (nbits < 0 || k < nbits) begin
               bit_q.push_back('{n + 1 + i * (PAT_W + gap) + b, pat[PAT_W-1-b]});
            end
            k++;
         end
      end
      if (exp_done) done_q.push_back(n + 1 + PAT_W * r + gap * (r - 1));
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with request inputs scrambled.
   task automatic request(input bit ud, input logic [3:0] pat, input int rep, input int gap,
                          input int nbits, input bit exp_done, output int n);
      int         waited = 0;
      logic [3:0] exp_pat;
      int         r_eff;
      bus.start_valid = 1'b1;
      bus.use_default = ud;
      bus.pat_in      = pat;
      bus.rep_cnt     = CNT_W'(rep);
      bus.gap_len     = GAP_W'(gap);
      #1;
      while (!bus.start_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.start_ready) begin
         unexpected("start_ready_timeout");
      end
      n       = cyc;
      exp_pat = ud ? 4'b1011 : pat;
      r_eff   = (rep == 0) ? 1 : rep;
      push_exp(exp_pat, r_eff, gap, n, nbits, exp_done);
      @(negedge clk);
      bus.start_valid = 1'b0;
      bus.use_default = ~ud;
      bus.pat_in      = ~pat;
      bus.rep_cnt     = '0;
      bus.gap_len     = 4'hF;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain(input int limit);
      int w = 0;
      while ((bit_q.size() != 0 || done_q.size() != 0) && w < limit) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      check("drain_bits", bit_q.size(), 0);
      check("drain_done", done_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n2;
      bus.start_valid = 1'b0;
      bus.use_default = 1'b0;
      bus.pat_in      = '0;
      bus.rep_cnt     = '0;
      bus.gap_len     = '0;
      bus.abort       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", bus.dout, 0);
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_start_ready", bus.start_ready, 1);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // 1: default pattern, R=1, no gap
      request(1'b1, 4'b0000, 1, 0, -1, 1'b1, n);
      wait_cyc(n + 2);
      check("t1_busy_shift", bus.busy, 1);
      wait_cyc(n + 5);
      check("t1_busy_done", bus.busy, 0);
      check("t1_ready_in_done", bus.start_ready, 0);
      wait_cyc(n + 6);
      check("t1_ready_after", bus.start_ready, 1);
      drain(20);

      // 2: user pattern 0110, R=3, gap=2; inputs change after acceptance
      request(1'b0, 4'b0110, 3, 2, -1, 1'b1, n);
      wait_cyc(n + 5);
      check("t2_gap_busy", bus.busy, 1);
      check("t2_gap_valid", bus.dout_valid, 0);
      drain(40);

      // 3: loopback stream 10111011 through a bench-side 1011 detector
      hist    = 3'b000;
      det_cnt = 0;
      request(1'b1, 4'b0000, 2, 0, -1, 1'b1, n);
      drain(30);
      check("t3_detections", det_cnt, 2);

      // 4: abort in the third SHIFT cycle of R=2, restart the cycle after
      request(1'b1, 4'b0000, 2, 0, 3, 1'b0, n);
      wait_cyc(n + 3);
      bus.abort = 1'b1;
      wait_cyc(n + 4);
      check("t4_valid_after_abort", bus.dout_valid, 0);
      check("t4_busy_after_abort", bus.busy, 0);
      check("t4_done_after_abort", bus.done, 0);
      bus.abort = 1'b0;
      request(1'b0, 4'b1100, 1, 0, -1, 1'b1, n2);
      check("t4_restart_cycle", n2, n + 4);
      drain(20);

      // 5: reset during GAP, then rep_cnt=0 sends one pattern
      request(1'b1, 4'b0000, 2, 3, 4, 1'b0, n);
      wait_cyc(n + 5);
      check("t5_in_gap_busy", bus.busy, 1);
      rst_n = 1'b0;
      wait_cyc(n + 6);
      check("t5_rst_dout", bus.dout, 0);
      check("t5_rst_valid", bus.dout_valid, 0);
      check("t5_rst_busy", bus.busy, 0);
      check("t5_rst_done", bus.done, 0);
      rst_n = 1'b1;
      request(1'b0, 4'b1101, 0, 0, -1, 1'b1, n);
      drain(20);

      // 6: start with abort in IDLE is refused; start held while busy waits for IDLE
      bus.abort       = 1'b1;
      bus.start_valid = 1'b1;
      bus.use_default = 1'b1;
      bus.rep_cnt     = 8'd1;
      bus.gap_len     = '0;
      #1;
      check("t6_ready_abort", bus.start_ready, 0);
      @(negedge clk);
      check("t6_not_accepted_busy", bus.busy, 0);
      check("t6_not_accepted_valid", bus.dout_valid, 0);
      bus.abort = 1'b0;
      request(1'b1, 4'b0000, 1, 0, -1, 1'b1, n);
      bus.start_valid = 1'b1;
      bus.use_default = 1'b0;
      bus.pat_in      = 4'b0100;
      bus.rep_cnt     = 8'd1;
      bus.gap_len     = '0;
      n2 = -1;
      for (int c = n + 1; c <= n + 6; c++) begin
         wait_cyc(c);
         #1;
         if (c < n + 6) begin
            check("t6_held_ready_low", bus.start_ready, 0);
         end else begin
            check("t6_held_ready_high", bus.start_ready, 1);
            n2 = cyc;
            push_exp(4'b0100, 1, 0, n2, -1, 1'b1);
         end
      end
      check("t6_held_accept_cycle", n2, n + 6);
      @(negedge clk);
      bus.start_valid = 1'b0;
      drain(20);

      // 7: maximum repeat count, no wrap
      request(1'b0, 4'b1001, 255, 0, -1, 1'b1, n);
      drain(1100);

      repeat (3) @(negedge clk);
      check("final_bits_empty", bit_q.size(), 0);
      check("final_done_empty", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
